// File: rtl/timing_check_monitor_if.sv
// Signal bundle between timing_check_monitor and the logic it watches.
// The skew-check signals exist only when TCM_SKEW_CHECK_EN is defined.
interface timing_check_monitor_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]    data;
    logic             ref_sig;
    logic             clr;
    logic [CH-1:0]    viol_setup;
    logic [CH-1:0]    viol_hold;
    logic [CH-1:0]    sticky;
    logic [CNT_W-1:0] viol_cnt;
    logic             irq;
`ifdef TCM_SKEW_CHECK_EN
    logic             ref2_sig;
    logic             viol_skew;
    logic             sticky_skew;

    modport master (
        output data, ref_sig, ref2_sig, clr,
        input  viol_setup, viol_hold, viol_skew, sticky, sticky_skew, viol_cnt, irq
    );
    modport slave (
        input  data, ref_sig, ref2_sig, clr,
        output viol_setup, viol_hold, viol_skew, sticky, sticky_skew, viol_cnt, irq
    );
`else
    modport master (
        output data, ref_sig, clr,
        input  viol_setup, viol_hold, sticky, viol_cnt, irq
    );
    modport slave (
        input  data, ref_sig, clr,
        output viol_setup, viol_hold, sticky, viol_cnt, irq
    );
`endif
endinterface

// File: rtl/timing_check_monitor.sv
// Cycle-based setup/hold (and optional skew) checker for CH synchronous channels.
// Define TCM_SKEW_CHECK_EN to build the ref_sig -> ref2_sig skew check.
module timing_check_monitor #(
    parameter int CH        = 4,
    parameter int CNT_W     = 8,
    parameter int SETUP_LIM = 2,
    parameter int HOLD_LIM  = 1,
    parameter int SKEW_LIM  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    timing_check_monitor_if.slave  bus
);
    localparam int               INC_W    = $clog2(2 * CH + 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETUP_L  = CNT_W'(SETUP_LIM);
    localparam logic [CNT_W-1:0] HOLD_L   = CNT_W'(HOLD_LIM);

    function automatic logic [INC_W-1:0] popcount(input logic [CH-1:0] v);
        logic [INC_W-1:0] n;
        n = {INC_W{1'b0}};
        for (int i = 0; i < CH; i++) begin
            n = n + {{(INC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [CH-1:0]          data_q_r;
    logic                   ref_q_r;
    logic [CNT_W-1:0]       since_chg_r [CH];
    logic [CNT_W-1:0]       hold_cnt_r;
    logic [CH-1:0]          viol_setup_r, viol_hold_r, sticky_r;
    logic [CNT_W-1:0]       viol_cnt_r;
    logic                   irq_r;

    logic [CH-1:0]          chg_s, setup_v_s, hold_v_s, sticky_nxt_s;
    logic [CNT_W-1:0]       dist_s [CH];
    logic                   ref_rise_s;
    logic                   skew_v_s;
    logic                   sticky_skew_nxt_s;
    logic [INC_W-1:0]       inc_s;
    logic [CNT_W+INC_W-1:0] sum_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    // Edge detection, setup/hold violation decode and next sticky/count values
    always_comb begin
        chg_s      = bus.data ^ data_q_r;
        ref_rise_s = bus.ref_sig & ~ref_q_r;
        for (int i = 0; i < CH; i++) begin
            dist_s[i]    = chg_s[i] ? CNT_ZERO : since_chg_r[i];
            setup_v_s[i] = ref_rise_s & (dist_s[i] < SETUP_L);
            hold_v_s[i]  = chg_s[i] & ~ref_rise_s & (hold_cnt_r != CNT_ZERO);
        end
        // A violation in the same cycle as clr survives the clear
        sticky_nxt_s = (bus.clr ? {CH{1'b0}} : sticky_r) | setup_v_s | hold_v_s;
        inc_s = popcount(setup_v_s) + popcount(hold_v_s) + {{(INC_W-1){1'b0}}, skew_v_s};
        sum_s = {{INC_W{1'b0}}, (bus.clr ? CNT_ZERO : viol_cnt_r)} + {{CNT_W{1'b0}}, inc_s};
        if (sum_s > {{INC_W{1'b0}}, CNT_MAX}) begin
            cnt_nxt_s = CNT_MAX;
        end else begin
            cnt_nxt_s = sum_s[CNT_W-1:0];
        end
    end

    // Input history, per-channel change distance and hold window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q_r   <= {CH{1'b0}};
            ref_q_r    <= 1'b0;
            hold_cnt_r <= CNT_ZERO;
            for (int i = 0; i < CH; i++) since_chg_r[i] <= CNT_MAX;
        end else begin
            data_q_r <= bus.data;
            ref_q_r  <= bus.ref_sig;
            if (ref_rise_s) begin
                hold_cnt_r <= HOLD_L;
            end else if (hold_cnt_r != CNT_ZERO) begin
                hold_cnt_r <= hold_cnt_r - CNT_ONE;
            end
            for (int i = 0; i < CH; i++) begin
                if (chg_s[i]) begin
                    since_chg_r[i] <= CNT_ONE;
                end else if (since_chg_r[i] != CNT_MAX) begin
                    since_chg_r[i] <= since_chg_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Registered violation pulses, sticky flags, saturating count and interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_setup_r <= {CH{1'b0}};
            viol_hold_r  <= {CH{1'b0}};
            sticky_r     <= {CH{1'b0}};
            viol_cnt_r   <= CNT_ZERO;
            irq_r        <= 1'b0;
        end else begin
            viol_setup_r <= setup_v_s;
            viol_hold_r  <= hold_v_s;
            sticky_r     <= sticky_nxt_s;
            viol_cnt_r   <= cnt_nxt_s;
            irq_r        <= (|sticky_nxt_s) | sticky_skew_nxt_s;
        end
    end

    assign bus.viol_setup = viol_setup_r;
    assign bus.viol_hold  = viol_hold_r;
    assign bus.sticky     = sticky_r;
    assign bus.viol_cnt   = viol_cnt_r;
    assign bus.irq        = irq_r;

`ifdef TCM_SKEW_CHECK_EN
    typedef enum logic {SK_IDLE = 1'b0, SK_ARMED = 1'b1} skew_state_t;

    localparam logic [CNT_W:0] SKEW_END = (CNT_W+1)'(SKEW_LIM + 1);

    skew_state_t    skew_state_r;
    logic [CNT_W-1:0] skew_cnt_r;
    logic           ref2_q_r;
    logic           viol_skew_r, sticky_skew_r;
    logic [CNT_W:0] skew_next_s;

    // A late ref2 rise (at the limit+1 cycle) is also a violation; a new ref edge restarts
    always_comb begin
        skew_next_s       = {1'b0, skew_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        skew_v_s          = (skew_state_r == SK_ARMED) & ~ref_rise_s & (skew_next_s == SKEW_END);
        sticky_skew_nxt_s = (bus.clr ? 1'b0 : sticky_skew_r) | skew_v_s;
    end

    // Skew FSM with its registered pulse and sticky flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_state_r  <= SK_IDLE;
            skew_cnt_r    <= CNT_ZERO;
            ref2_q_r      <= 1'b0;
            viol_skew_r   <= 1'b0;
            sticky_skew_r <= 1'b0;
        end else begin
            ref2_q_r      <= bus.ref2_sig;
            viol_skew_r   <= skew_v_s;
            sticky_skew_r <= sticky_skew_nxt_s;
            case (skew_state_r)
                SK_IDLE: begin
                    if (ref_rise_s) begin
                        skew_state_r <= SK_ARMED;
                        skew_cnt_r   <= CNT_ZERO;
                    end
                end
                SK_ARMED: begin
                    if (ref_rise_s) begin
                        skew_cnt_r <= CNT_ZERO;
                    end else if ((bus.ref2_sig & ~ref2_q_r) || skew_v_s) begin
                        skew_state_r <= SK_IDLE;
                        skew_cnt_r   <= CNT_ZERO;
                    end else begin
                        skew_cnt_r <= skew_next_s[CNT_W-1:0];
                    end
                end
                default: begin
                    skew_state_r <= SK_IDLE;
                    skew_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.viol_skew   = viol_skew_r;
    assign bus.sticky_skew = sticky_skew_r;
`else
    assign skew_v_s          = 1'b0;
    assign sticky_skew_nxt_s = 1'b0;
`endif

endmodule
